ctrl_event_rec_11: RTL

- Records the switching schedule of one `EXTENDED_SINGLE` control signal as up to 11 (time, value) pairs plus an initial value.
- Stored time and value pairs use the same format as the time_1..time_11 / value_1..value_11 inputs of the ctrl_time family, so a captured waveform can be replayed directly.
- Sits beside the simulation step counter. Captures on every valid sample; read back through a registered random-access port.

---
 rtl/ctrl_event_rec_11_pkg.sv | 16 +
 rtl/ctrl_event_rec_11_evt_table.sv | 70 +++++++
 rtl/ctrl_event_rec_11.sv | 92 +++++++++
 3 files changed

// File: rtl/ctrl_event_rec_11_pkg.sv
// Shared widths and state encoding for the control-signal event recorder.
// EXTENDED_SINGLE is the width of one double-precision control value.
package ctrl_event_rec_11_pkg;

    localparam int EXTENDED_SINGLE = 64;
    localparam int CTRL_N_EVT      = 11;
    localparam int CTRL_TIME_W     = 12;
    localparam int CTRL_IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_REC  = 2'd1,
        ST_FULL = 2'd2
    } rec_state_t;

endpackage

// File: rtl/ctrl_event_rec_11_evt_table.sv
// Event slot register file: one write port and one registered read port.
// Slot indices run 1..N_EVT; any other index, or an unfilled slot, reads as zero.
module ctrl_evt_table
    import ctrl_event_rec_11_pkg::*;
#(
    parameter int N_EVT  = CTRL_N_EVT,
    parameter int TIME_W = CTRL_TIME_W,
    parameter int VAL_W  = EXTENDED_SINGLE,
    parameter int IDX_W  = CTRL_IDX_W
) (
    input  logic              clk,
    input  logic              sta_n,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TIME_W-1:0] wr_time,
    input  logic [VAL_W-1:0]  wr_value,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [IDX_W-1:0]  rd_lim,
    output logic              rd_vld,
    output logic [TIME_W-1:0] rd_time,
    output logic [VAL_W-1:0]  rd_value
);

    logic [TIME_W-1:0] slot_time  [N_EVT];
    logic [VAL_W-1:0]  slot_value [N_EVT];

    logic [IDX_W-1:0] wr_slot;
    logic [IDX_W-1:0] rd_slot;
    logic             rd_ok;

    assign wr_slot = wr_idx - IDX_W'(1);
    assign rd_slot = rd_idx - IDX_W'(1);
    assign rd_ok   = (rd_idx != '0) && (rd_idx <= rd_lim) && (rd_idx <= IDX_W'(N_EVT));

    // NOTE: the slots are cleared on reset on purpose: a replay of a freshly
    // armed table must see zero times and values, not power-up garbage.
    // NOTE: non-blocking assignments make a same-edge read return the table
    // contents from before this edge's write.
    always_ff @(posedge clk) begin
        if (!sta_n) begin
            for (int i = 0; i < N_EVT; i++) begin
                slot_time[i]  <= '0;
                slot_value[i] <= '0;
            end
            rd_vld   <= 1'b0;
            rd_time  <= '0;
            rd_value <= '0;
        end else if (clr) begin
            // The last read result stays visible; only the request is dropped.
            for (int i = 0; i < N_EVT; i++) begin
                slot_time[i]  <= '0;
                slot_value[i] <= '0;
            end
            rd_vld <= 1'b0;
        end else begin
            if (we) begin
                slot_time[wr_slot]  <= wr_time;
                slot_value[wr_slot] <= wr_value;
            end
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_time  <= rd_ok ? slot_time[rd_slot]  : '0;
                rd_value <= rd_ok ? slot_value[rd_slot] : '0;
            end
        end
    end

endmodule

// File: rtl/ctrl_event_rec_11.sv
// Records up to N_EVT (time, value) switch events of one control signal,
// in the replay format of the ctrl_time family, plus its initial value.
module ctrl_event_rec_11
    import ctrl_event_rec_11_pkg::*;
#(
    parameter int N_EVT  = CTRL_N_EVT,
    parameter int TIME_W = CTRL_TIME_W,
    parameter int IDX_W  = CTRL_IDX_W
) (
    input  logic                       clk,
    input  logic                       sta_n,
    input  logic                       clr,
    input  logic                       run,
    input  logic [TIME_W-1:0]          counter,
    input  logic                       x_vld,
    input  logic [EXTENDED_SINGLE-1:0] x,
    input  logic                       rd_req,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic                       rd_vld,
    output logic [TIME_W-1:0]          rd_time,
    output logic [EXTENDED_SINGLE-1:0] rd_value,
    output logic [EXTENDED_SINGLE-1:0] init_value,
    output logic [IDX_W-1:0]           evt_cnt,
    output logic                       full,
    output logic                       ovf
);

    rec_state_t                 state;
    logic [EXTENDED_SINGLE-1:0] prev;
    logic                       sample;
    logic                       changed;
    logic                       we;

    assign sample  = run && x_vld;
    assign changed = (x != prev);
    assign we      = sample && (state == ST_REC) && changed;
    assign full    = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (!sta_n || clr) begin
            state      <= ST_ARM;
            prev       <= '0;
            init_value <= '0;
            evt_cnt    <= '0;
            ovf        <= 1'b0;
        end else if (sample) begin
            case (state)
                ST_ARM: begin
                    init_value <= x;
                    prev       <= x;
                    state      <= ST_REC;
                end
                ST_REC: begin
                    if (changed) begin
                        evt_cnt <= evt_cnt + IDX_W'(1);
                        prev    <= x;
                        if (evt_cnt == IDX_W'(N_EVT - 1))
                            state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (changed)
                        ovf <= 1'b1;
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    // Stored time is counter+1 so the replay block switches on counter == time-1.
    ctrl_evt_table #(
        .N_EVT  (N_EVT),
        .TIME_W (TIME_W),
        .VAL_W  (EXTENDED_SINGLE),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk      (clk),
        .sta_n    (sta_n),
        .clr      (clr),
        .we       (we),
        .wr_idx   (evt_cnt + IDX_W'(1)),
        .wr_time  (counter + TIME_W'(1)),
        .wr_value (x),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .rd_lim   (evt_cnt),
        .rd_vld   (rd_vld),
        .rd_time  (rd_time),
        .rd_value (rd_value)
    );

endmodule
